hex_bcd_display_ctrl: RTL and testbench
=======================================

Name: hex_bcd_display_ctrl

Overview:
- Sequencing controller for the board's six 7-segment displays (HEX5..HEX0).
- Accepts a binary value over a valid/ready handshake and converts it to six BCD digits with a multi-cycle shift-add-3 (double-dabble) sequence.
- Encodes the digits to active-low segment patterns and holds them on HEX0..HEX5 until the next accepted value.
- Replaces the static per-digit divide/mod decoding with one sequenced, shared conversion datapath.

Parameters:
WIDTH, 20, binary input width; valid range 4..20; conversion takes WIDTH shift cycles
BLANK_LZ, 1, 1 = blank leading-zero digits (HEX0 always shown); 0 = show all six digits

Ports:
CLOCK_50  input  1  system clock, 50 MHz, all logic on its rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request to display in_data
in_data  input  WIDTH  unsigned binary value
in_ready  output  1  high when the controller can accept a value (IDLE state)
disp_en  input  1  0 forces all HEX outputs to blank (7'b1111111) combinationally; internal registers are unaffected
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when HEX outputs update
overflow  output  1  registered; 1 if the last displayed value exceeded 999999
HEX0..HEX5  output  7 each  active-low segments, bit0 = A .. bit6 = G; HEX0 = least-significant digit

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all HEX registers = 7'b1111111; busy = 0; done = 0; overflow = 0; shift and count registers cleared. A conversion in progress is aborted and nothing is displayed.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111, dash = 0111111
- FSM states: IDLE, CONV, UPDATE.
- IDLE:
  - in_ready = 1.
  - Accept occurs on an edge N where in_valid = 1.
  - At that edge: latch in_data into the binary shift register, clear the 24-bit BCD register, set count = 0, latch ovf_pend = (in_data > 999999), go to CONV.
- CONV:
  - in_ready = 0, busy = 1.
  - Each edge: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1 and count increments.
  - After WIDTH shift edges (edges N+1 .. N+WIDTH), go to UPDATE.
- UPDATE (edge N+WIDTH+1):
  - Write the HEX registers and set overflow = ovf_pend.
  - done = 1 for exactly the cycle following this edge; go to IDLE.
  - busy drops and in_ready rises in that same cycle.
- Latency and throughput: with WIDTH = 20, outputs change at edge N+21. The earliest next accept is edge N+22, so throughput is one value per 22 cycles.
- in_valid and in_data are ignored outside IDLE; no queuing. The previous display holds throughout a conversion.
- Overflow: if ovf_pend = 1, all six HEX show dash. Conversion still runs the full WIDTH cycles, so latency is identical.
- Leading zeros (BLANK_LZ = 1): blank every digit above the most significant nonzero digit. Value 0 shows "0" on HEX0 with HEX5..HEX1 blank. BLANK_LZ = 0 shows all digits, including leading zeros.
- disp_en only masks the outputs. Toggling it does not affect the FSM, done, or overflow.
- Arithmetic: the BCD register is 24 bits (6 nibbles); the add-3 is per nibble in 4 bits. For WIDTH < 20, overflow is always 0.

Test Plan:
1. Reset, then in_valid = 1 with in_data = 59 at edge N:
   - in_ready = 0 from N+1; done = 1 after edge N+21.
   - HEX0 = 0010000, HEX1 = 0010010, HEX2..HEX5 = 1111111, overflow = 0.
2. in_data = 0:
   - HEX0 = 1000000, HEX1..HEX5 = 1111111.
   - Then in_data = 999999: all HEX = 0010000.
3. in_data = 1000000:
   - All HEX = 0111111, overflow = 1.
   - A following in_data = 7 clears overflow to 0; HEX0 = 1111000, others blank.
4. Hold in_valid = 1 continuously with in_data changing every cycle:
   - Accepts occur exactly every 22 cycles, each using the in_data present at its accept edge.
   - done pulses are single-cycle, 22 cycles apart.
5. Assert reset at edge N+10 of a conversion of 123456:
   - All HEX blank immediately, in_ready = 1, no done pulse.
   - The next accept of 42 displays HEX1 = 0011001, HEX0 = 0100100.
6. BLANK_LZ = 0, in_data = 59:
   - HEX5..HEX2 = 1000000.
   - Then disp_en = 0: all HEX = 1111111 in the same cycle. disp_en = 1 restores the digits without a new conversion.

Source files
------------

// File: rtl/hex_bcd_display_ctrl_if.sv
// Handshake and display bus between a value producer and the 7-segment controller.
// Latency: none, wires only.
// Backpressure: in_ready is low whenever the controller is converting.
interface hex_bcd_display_ctrl_if #(
   parameter int WIDTH = 20
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             disp_en;
   logic             busy;
   logic             done;
   logic             overflow;
   logic [6:0]       HEX0;
   logic [6:0]       HEX1;
   logic [6:0]       HEX2;
   logic [6:0]       HEX3;
   logic [6:0]       HEX4;
   logic [6:0]       HEX5;

   // Producer side: offers values and controls display enable.
   modport master (
      output in_valid, in_data, disp_en,
      input  in_ready, busy, done, overflow,
      input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );

   // Controller side.
   modport slave (
      input  in_valid, in_data, disp_en,
      output in_ready, busy, done, overflow,
      output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
   );
endinterface

// File: rtl/hex_bcd_display_ctrl.sv
// Binary-to-BCD (double-dabble) sequencer driving six active-low 7-segment displays.
// Latency: accept edge N, HEX/overflow update at edge N+WIDTH+1, done high the cycle after.
// Backpressure: in_ready only in IDLE; in_valid/in_data ignored while converting, no queuing.
module hex_bcd_display_ctrl #(
   parameter int WIDTH    = 20,
   parameter bit BLANK_LZ = 1'b1
) (
   input logic CLOCK_50,
   input logic reset,
   hex_bcd_display_ctrl_if.slave bus
);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

   state_t           state;
   logic [WIDTH-1:0] bin_sr;
   logic [23:0]      bcd;
   logic [4:0]       count;
   logic             ovf_pend;
   logic             busy_q;
   logic             done_q;
   logic             ovf_q;
   logic [6:0]       hex_q    [6];

   logic [23:0]      bcd_adj;
   logic [23:0]      bcd_shift;
   logic [6:0]       seg_next [6];
   logic             lead;
   logic [3:0]       nib;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 6; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      // Carry out of the top nibble is dropped; such values are shown as dashes anyway.
      bcd_shift = (bcd_adj << 1) | {23'd0, bin_sr[WIDTH-1]};
   end

   // Segment patterns for the finished BCD value, with dashes on overflow and optional leading-zero blanking.
   always_comb begin
      lead = BLANK_LZ;
      nib  = 4'd0;
      for (int i = 5; i >= 0; i--) begin
         nib = bcd[4*i +: 4];
         if (ovf_pend) begin
            seg_next[i] = SEG_DASH;
         end else if (lead && nib == 4'd0 && i != 0) begin
            seg_next[i] = SEG_BLANK;
         end else begin
            seg_next[i] = seg7(nib);
            lead        = 1'b0;
         end
      end
   end

   // Control FSM: accept, WIDTH shift cycles, then a single display-update cycle.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bin_sr   <= '0;
         bcd      <= '0;
         count    <= '0;
         ovf_pend <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bin_sr   <= bus.in_data;
                  bcd      <= '0;
                  count    <= '0;
                  ovf_pend <= (24'(bus.in_data) > 24'd999999);
                  busy_q   <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               bcd    <= bcd_shift;
               bin_sr <= bin_sr << 1;
               count  <= count + 5'd1;
               if (count == 5'(WIDTH - 1))
                  state <= UPDATE;
            end
            UPDATE: begin
               for (int i = 0; i < 6; i++) hex_q[i] <= seg_next[i];
               ovf_q  <= ovf_pend;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready = (state == IDLE);
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.overflow = ovf_q;

   // disp_en only masks the pins; the held display registers are untouched.
   assign bus.HEX0 = bus.disp_en ? hex_q[0] : SEG_BLANK;
   assign bus.HEX1 = bus.disp_en ? hex_q[1] : SEG_BLANK;
   assign bus.HEX2 = bus.disp_en ? hex_q[2] : SEG_BLANK;
   assign bus.HEX3 = bus.disp_en ? hex_q[3] : SEG_BLANK;
   assign bus.HEX4 = bus.disp_en ? hex_q[4] : SEG_BLANK;
   assign bus.HEX5 = bus.disp_en ? hex_q[5] : SEG_BLANK;
endmodule

// File: tb/tb_hex_bcd_display_ctrl.sv
// Self-checking bench for hex_bcd_display_ctrl: table of directed values plus multi-cycle sequences.
// Two instances: leading-zero blanking on (dut_a) and off (dut_b).
// Inputs driven on the falling edge, outputs sampled on the falling edge or just after a rising edge.
module tb_hex_bcd_display_ctrl;
   localparam logic [6:0] B  = 7'b1111111;
   localparam logic [6:0] DS = 7'b0111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;

   logic CLOCK_50 = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   hex_bcd_display_ctrl_if #(.WIDTH(20)) ifa ();
   hex_bcd_display_ctrl_if #(.WIDTH(20)) ifb ();

   hex_bcd_display_ctrl #(.WIDTH(20), .BLANK_LZ(1'b1)) dut_a (.CLOCK_50(CLOCK_50), .reset(reset), .bus(ifa));
   hex_bcd_display_ctrl #(.WIDTH(20), .BLANK_LZ(1'b0)) dut_b (.CLOCK_50(CLOCK_50), .reset(reset), .bus(ifb));

   typedef struct {
      logic [19:0] d;
      logic [41:0] hex;
      logic        ovf;
      string       nm;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [41:0] hexv(input bit b);
      return b ? {ifb.HEX5, ifb.HEX4, ifb.HEX3, ifb.HEX2, ifb.HEX1, ifb.HEX0}
               : {ifa.HEX5, ifa.HEX4, ifa.HEX3, ifa.HEX2, ifa.HEX1, ifa.HEX0};
   endfunction
   function automatic logic rdy(input bit b);   return b ? ifb.in_ready : ifa.in_ready; endfunction
   function automatic logic bsy(input bit b);   return b ? ifb.busy     : ifa.busy;     endfunction
   function automatic logic dn(input bit b);    return b ? ifb.done     : ifa.done;     endfunction
   function automatic logic ovf(input bit b);   return b ? ifb.overflow : ifa.overflow; endfunction

   task automatic set_in(input bit b, input logic v, input logic [19:0] d);
      if (b) begin ifb.in_valid = v; ifb.in_data = d; end
      else   begin ifa.in_valid = v; ifa.in_data = d; end
   endtask

   // Reference digit encoding by divide/mod, blanking leading zeros.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
         5: return S5; 6: return S6; 7: return S7; 8: return S8; default: return S9;
      endcase
   endfunction
   function automatic logic [41:0] model_hex(input int v);
      logic [41:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0 && v < p) r[7*i +: 7] = B;
         else                r[7*i +: 7] = seg_of((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // One full transaction: accept, latency check, capture display at the done cycle, done width check.
   task automatic conv(input bit b, input logic [19:0] d, input string nm,
                       output logic [41:0] hx, output logic ov);
      int cyc;
      @(negedge CLOCK_50);
      chk({nm, ".ready_before"}, 64'(rdy(b)), 64'd1);
      set_in(b, 1'b1, d);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      set_in(b, 1'b0, 20'd0);
      chk({nm, ".ready_low"}, 64'(rdy(b)), 64'd0);
      chk({nm, ".busy_high"}, 64'(bsy(b)), 64'd1);
      cyc = 0;
      while (!dn(b) && cyc < 40) begin
         @(negedge CLOCK_50);
         cyc++;
      end
      chk({nm, ".latency"}, 64'(cyc), 64'd21);
      hx = hexv(b);
      ov = ovf(b);
      chk({nm, ".ready_at_done"}, 64'(rdy(b)), 64'd1);
      @(negedge CLOCK_50);
      chk({nm, ".done_single"}, 64'(dn(b)), 64'd0);
   endtask

   initial begin
      logic [41:0] hx;
      logic        ov;
      int          last_acc, last_done, n_done, pend, dcount, guard;

      vt[0] = '{d: 20'd59,      hex: {B, B, B, B, S5, S9},       ovf: 1'b0, nm: "v59"};
      vt[1] = '{d: 20'd0,       hex: {B, B, B, B, B, S0},        ovf: 1'b0, nm: "v0"};
      vt[2] = '{d: 20'd999999,  hex: {S9, S9, S9, S9, S9, S9},   ovf: 1'b0, nm: "v999999"};
      vt[3] = '{d: 20'd1000000, hex: {DS, DS, DS, DS, DS, DS},   ovf: 1'b1, nm: "v1000000"};
      vt[4] = '{d: 20'd7,       hex: {B, B, B, B, B, S7},        ovf: 1'b0, nm: "v7"};
      vt[5] = '{d: 20'd123456,  hex: {S1, S2, S3, S4, S5, S6},   ovf: 1'b0, nm: "v123456"};
      vt[6] = '{d: 20'd100,     hex: {B, B, B, S1, S0, S0},      ovf: 1'b0, nm: "v100"};
      vt[7] = '{d: 20'd8,       hex: {B, B, B, B, B, S8},        ovf: 1'b0, nm: "v8"};
      vt[8] = '{d: 20'hFFFFF,   hex: {DS, DS, DS, DS, DS, DS},   ovf: 1'b1, nm: "vmax"};

      reset = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.disp_en = 1'b1;
      ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.disp_en = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      chk("rst.hex",   hexv(0), {B, B, B, B, B, B});
      chk("rst.ready", 64'(rdy(0)), 64'd1);
      chk("rst.busy",  64'(bsy(0)), 64'd0);
      chk("rst.done",  64'(dn(0)),  64'd0);
      chk("rst.ovf",   64'(ovf(0)), 64'd0);
      reset = 1'b0;

      // Directed value table on the blanking instance.
      for (int i = 0; i < 9; i++) begin
         conv(1'b0, vt[i].d, vt[i].nm, hx, ov);
         chk({vt[i].nm, ".hex"}, hx, vt[i].hex);
         chk({vt[i].nm, ".ovf"}, 64'(ov), 64'(vt[i].ovf));
      end

      // Continuous in_valid with data changing every cycle.
      last_acc = -1; last_done = -1; n_done = 0; pend = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLOCK_50);
         if (ifa.done) begin
            n_done++;
            if (last_done >= 0) chk("stream.done_gap", 64'(i - last_done), 64'd22);
            chk("stream.hex", hexv(0), model_hex(pend));
            chk("stream.ovf", 64'(ovf(0)), 64'd0);
            last_done = i;
         end
         set_in(1'b0, 1'b1, 20'(300 + i * 13));
         if (ifa.in_ready) begin
            if (last_acc >= 0) chk("stream.accept_gap", 64'(i - last_acc), 64'd22);
            pend = 300 + i * 13;
            last_acc = i;
         end
      end
      chk("stream.done_count", 64'(n_done), 64'd3);
      set_in(1'b0, 1'b0, 20'd0);
      guard = 0;
      while (!ifa.done && guard < 40) begin
         @(negedge CLOCK_50);
         guard++;
      end
      chk("stream.drain", 64'(guard < 40), 64'd1);
      chk("stream.last_hex", hexv(0), model_hex(pend));
      @(negedge CLOCK_50);

      // Reset in the middle of a conversion.
      set_in(1'b0, 1'b1, 20'd123456);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      set_in(1'b0, 1'b0, 20'd0);
      repeat (9) @(posedge CLOCK_50);
      #1 reset = 1'b1;
      #1;
      chk("abort.hex",   hexv(0), {B, B, B, B, B, B});
      chk("abort.ready", 64'(rdy(0)), 64'd1);
      chk("abort.busy",  64'(bsy(0)), 64'd0);
      chk("abort.done",  64'(dn(0)),  64'd0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      dcount = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if (ifa.done) dcount++;
      end
      chk("abort.no_done", 64'(dcount), 64'd0);
      conv(1'b0, 20'd42, "v42", hx, ov);
      chk("v42.hex", hx, {B, B, B, B, S4, S2});

      // Leading zeros shown, then display masking.
      conv(1'b1, 20'd59, "nolz59", hx, ov);
      chk("nolz59.hex", hx, {S0, S0, S0, S0, S5, S9});
      chk("nolz59.ovf", 64'(ov), 64'd0);
      @(negedge CLOCK_50);
      ifb.disp_en = 1'b0;
      #1;
      chk("mask.hex",   hexv(1), {B, B, B, B, B, B});
      chk("mask.ready", 64'(rdy(1)), 64'd1);
      chk("mask.done",  64'(dn(1)),  64'd0);
      chk("mask.other", hexv(0), {B, B, B, B, S4, S2});
      @(negedge CLOCK_50);
      ifb.disp_en = 1'b1;
      #1;
      chk("unmask.hex", hexv(1), {S0, S0, S0, S0, S5, S9});
      chk("unmask.busy", 64'(bsy(1)), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
